// File: rtl/irq_src_gateway_if.sv
// Register-port bundle for irq_src_gateway: request/grant with a registered
// response one cycle after every grant.
interface irq_src_gateway_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  valid;
  logic [31:0]           rdata;
  logic                  error;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, valid, rdata, error
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, valid, rdata, error
  );
endinterface

// File: rtl/irq_src_gateway.sv
// Interrupt-source conditioner: 2-flop sync, optional debounce filter
// (IRQ_GATEWAY_DEBOUNCE_EN), level/edge conversion and a small register port.
module irq_src_gateway #(
  parameter int SOURCE_NUM      = 32,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SOURCE_NUM-1:0] intr_src_i,
  output logic [SOURCE_NUM-1:0] intr_o,
  irq_src_gateway_if.slave      s_mem
);

  localparam int DW = MEM_DATA_WIDTH;

  typedef logic [SOURCE_NUM-1:0] src_vec_t;

  src_vec_t sync_ff1;
  src_vec_t sync_q;
  src_vec_t filt;
  src_vec_t sync_d;
  src_vec_t rise;
  src_vec_t pending;
  src_vec_t edge_mode;
  src_vec_t edge_mode_wr;
  src_vec_t clr_vec;

  logic          upper_bad;
  logic          ro_write;
  logic          acc_err;
  logic          wr_ok;
  logic          edge_wr;
  logic          clr_wr;
  logic [1:0]    reg_sel;
  logic [DW-1:0] lane_mask;
  logic [DW-1:0] edge_word;
  logic [DW-1:0] clr_word;
  logic [DW-1:0] rd_word;
  logic          unused_addr_lsb;

  function automatic logic [DW-1:0] widen(input src_vec_t v);
    logic [DW-1:0] w;
    w = '0;
    w[SOURCE_NUM-1:0] = v;
    return w;
  endfunction

  // Handshake: gnt mirrors req combinationally, so every request is taken in
  // its request cycle; valid/rdata/error are registered and follow one cycle
  // after each grant. There is no backpressure in either direction.
  assign s_mem.gnt       = s_mem.req;
  assign unused_addr_lsb = ^s_mem.addr[1:0];

  always_comb begin
    upper_bad = |s_mem.addr[MEM_ADDR_WIDTH-1:4];
    reg_sel   = s_mem.addr[3:2];
    ro_write  = s_mem.we & reg_sel[0];
    acc_err   = upper_bad | ro_write;
    wr_ok     = s_mem.req & s_mem.we & ~acc_err;
    edge_wr   = wr_ok & (reg_sel == 2'd0);
    clr_wr    = wr_ok & (reg_sel == 2'd2);

    lane_mask = '0;
    for (int b = 0; b < 4; b++) begin
      lane_mask[b*8 +: 8] = {8{s_mem.be[b]}};
    end

    edge_word    = (widen(edge_mode) & ~lane_mask) | (s_mem.wdata & lane_mask);
    edge_mode_wr = edge_word[SOURCE_NUM-1:0];
    clr_word     = s_mem.wdata & lane_mask;
    clr_vec      = clr_wr ? clr_word[SOURCE_NUM-1:0] : '0;

    rd_word = '0;
    case (reg_sel)
      2'd0:    rd_word = widen(edge_mode);
      2'd1:    rd_word = widen(pending);
      2'd3:    rd_word = widen(sync_q);
      default: rd_word = '0;
    endcase
  end

`ifdef IRQ_GATEWAY_DEBOUNCE_EN
  logic [7:0] db_cnt [SOURCE_NUM];

  // The filtered value only follows sync after a full run of disagreement;
  // any agreeing sample restarts the run.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      filt <= '0;
      for (int i = 0; i < SOURCE_NUM; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SOURCE_NUM; i++) begin
        if (sync_q[i] != filt[i]) begin
          if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            filt[i]   <= sync_q[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign filt = sync_q;
`endif

  assign rise = filt & ~sync_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_ff1    <= '0;
      sync_q      <= '0;
      sync_d      <= '0;
      pending     <= '0;
      edge_mode   <= '0;
      intr_o      <= '0;
      s_mem.valid <= 1'b0;
      s_mem.rdata <= '0;
      s_mem.error <= 1'b0;
    end else begin
      sync_ff1 <= intr_src_i;
      sync_q   <= sync_ff1;
      sync_d   <= filt;
      // A rise outranks a same-cycle clear so no edge is lost; level sources
      // never hold a pending bit.
      pending  <= edge_mode & (rise | (pending & ~clr_vec));
      if (edge_wr) begin
        edge_mode <= edge_mode_wr;
      end
      intr_o      <= (edge_mode & pending) | (~edge_mode & filt);
      s_mem.valid <= s_mem.req;
      s_mem.error <= s_mem.req & acc_err;
      s_mem.rdata <= (s_mem.req & ~s_mem.we & ~upper_bad) ? rd_word : '0;
    end
  end

endmodule
